// File: rtl/control_sincronia_if.sv
`default_nettype none
// ============================================================================
// Module      : control_sincronia_if
// Description : Bundle of the serial-link synchronisation controller's data
//               and status signals.
//               master : drives s_in / forzar_busqueda, observes status
//               slave  : the controller itself
//   s_in             serial data, one bit per clk
//   forzar_busqueda  request to drop alignment and re-hunt
//   valido           high while locked
//   palabra          last framed ANCHO-bit word
//   palabra_lista    one-cycle strobe, palabra updated
//   estado           00 BUSCAR, 01 CONFIRMAR, 10 SINCRONIZADO
//   perdidas         saturating lock-loss count
// Revision    : 1.0 - initial release
// ============================================================================
interface control_sincronia_if #(
  parameter int ANCHO = 5
);
  logic             s_in;
  logic             forzar_busqueda;
  logic             valido;
  logic [ANCHO-1:0] palabra;
  logic             palabra_lista;
  logic [1:0]       estado;
  logic [7:0]       perdidas;

  modport master (
    output s_in, forzar_busqueda,
    input  valido, palabra, palabra_lista, estado, perdidas
  );

  modport slave (
    input  s_in, forzar_busqueda,
    output valido, palabra, palabra_lista, estado, perdidas
  );
endinterface
`default_nettype wire

// File: rtl/control_sincronia.sv
`default_nettype none
// ============================================================================
// Module      : control_sincronia
// Description : Serial-link synchronisation controller. Hunts the serial
//               stream bit-by-bit for SECUENCIA, confirms alignment over
//               N_CONFIRMA consecutive words, then frames ANCHO-bit words
//               until M_PIERDE consecutive SEC_REINICIO words drop lock.
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   control_sincronia_if.slave (s_in, forzar_busqueda in;
//         valido, palabra, palabra_lista, estado, perdidas out)
// Revision    : 1.0 - initial release
// ============================================================================
module control_sincronia #(
  parameter int               ANCHO        = 5,
  parameter logic [ANCHO-1:0] SECUENCIA    = 5'b10100,
  parameter logic [ANCHO-1:0] SEC_REINICIO = 5'b00000,
  parameter int               N_CONFIRMA   = 2,
  parameter int               M_PIERDE     = 2
) (
  input  wire logic             clk,
  input  wire logic             rst,
  control_sincronia_if.slave    bus
);

  localparam int c_CNT_W  = $clog2(ANCHO);
  localparam int c_CONF_W = $clog2(N_CONFIRMA + 1);
  localparam int c_PERD_W = $clog2(M_PIERDE + 1);

  localparam logic [c_CNT_W-1:0]  c_ULTIMA    = c_CNT_W'(ANCHO - 1);
  localparam logic [c_CONF_W-1:0] c_CONF_MAX  = c_CONF_W'(N_CONFIRMA);
  localparam logic [c_PERD_W-1:0] c_PERD_MAX  = c_PERD_W'(M_PIERDE);

  typedef enum logic [1:0] {
    BUSCAR       = 2'b00,
    CONFIRMAR    = 2'b01,
    SINCRONIZADO = 2'b10
  } t_estado;

  // Registered state
  t_estado               r_estado;
  logic [ANCHO-2:0]      r_sr;
  logic [c_CNT_W-1:0]    r_llenado;
  logic [c_CNT_W-1:0]    r_fase;
  logic [c_CONF_W-1:0]   r_conf;
  logic [c_PERD_W-1:0]   r_perd;
  logic                  r_valido;
  logic [ANCHO-1:0]      r_palabra;
  logic                  r_lista;
  logic [7:0]            r_perdidas;

  // Next-state values
  t_estado               w_estado_sig;
  logic [c_CNT_W-1:0]    w_fase_sig;
  logic [c_CONF_W-1:0]   w_conf_sig;
  logic [c_PERD_W-1:0]   w_perd_sig;
  logic [ANCHO-1:0]      w_palabra_sig;
  logic                  w_lista_sig;
  logic [7:0]            w_perdidas_sig;

  // The compare window includes the bit being sampled on this edge.
  logic [ANCHO-1:0]      w_ventana;
  logic                  w_lleno;
  logic                  w_frontera;
  logic                  w_es_sec;
  logic                  w_es_reinicio;

  assign w_ventana     = {r_sr, bus.s_in};
  // ANCHO-1 bits already held plus the current one make a full window.
  assign w_lleno       = (r_llenado == c_ULTIMA);
  assign w_frontera    = (r_fase == c_ULTIMA);
  assign w_es_sec      = (w_ventana == SECUENCIA);
  assign w_es_reinicio = (w_ventana == SEC_REINICIO);

  always_comb begin
    w_estado_sig   = r_estado;
    w_fase_sig     = w_frontera ? '0 : r_fase + c_CNT_W'(1);
    w_conf_sig     = r_conf;
    w_perd_sig     = r_perd;
    w_palabra_sig  = r_palabra;
    w_lista_sig    = 1'b0;
    w_perdidas_sig = r_perdidas;

    case (r_estado)
      BUSCAR: begin
        // Sliding search; forzar_busqueda has no effect here.
        if (w_lleno && w_es_sec) begin
          // Phase restarts so the next boundary lands ANCHO edges later.
          w_fase_sig = '0;
          if (N_CONFIRMA == 1) begin
            w_estado_sig = SINCRONIZADO;
            w_conf_sig   = '0;
            w_perd_sig   = '0;
          end else begin
            w_estado_sig = CONFIRMAR;
            w_conf_sig   = c_CONF_W'(1);
          end
        end
      end

      CONFIRMAR: begin
        if (bus.forzar_busqueda) begin
          w_estado_sig = BUSCAR;
          w_conf_sig   = '0;
          w_perd_sig   = '0;
        end else if (w_frontera) begin
          if (w_es_sec) begin
            if (r_conf + c_CONF_W'(1) == c_CONF_MAX) begin
              w_estado_sig = SINCRONIZADO;
              w_conf_sig   = '0;
              w_perd_sig   = '0;
            end else begin
              w_conf_sig = r_conf + c_CONF_W'(1);
            end
          end else begin
            w_estado_sig = BUSCAR;
            w_conf_sig   = '0;
          end
        end
      end

      SINCRONIZADO: begin
        // A forced re-hunt wins over a coincident boundary.
        if (bus.forzar_busqueda) begin
          w_estado_sig = BUSCAR;
          w_conf_sig   = '0;
          w_perd_sig   = '0;
        end else if (w_frontera) begin
          w_palabra_sig = w_ventana;
          w_lista_sig   = 1'b1;
          if (w_es_reinicio) begin
            if (r_perd + c_PERD_W'(1) == c_PERD_MAX) begin
              w_estado_sig   = BUSCAR;
              w_perd_sig     = '0;
              w_perdidas_sig = (r_perdidas == 8'hFF) ? r_perdidas
                                                     : r_perdidas + 8'd1;
            end else begin
              w_perd_sig = r_perd + c_PERD_W'(1);
            end
          end else begin
            w_perd_sig = '0;
          end
        end
      end

      default: begin
        // Unused encoding recovers to hunting.
        w_estado_sig = BUSCAR;
        w_conf_sig   = '0;
        w_perd_sig   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_estado   <= BUSCAR;
      r_sr       <= '0;
      r_llenado  <= '0;
      r_fase     <= '0;
      r_conf     <= '0;
      r_perd     <= '0;
      r_valido   <= 1'b0;
      r_palabra  <= '0;
      r_lista    <= 1'b0;
      r_perdidas <= '0;
    end else begin
      r_estado   <= w_estado_sig;
      r_sr       <= w_ventana[ANCHO-2:0];
      if (!w_lleno) begin
        r_llenado <= r_llenado + c_CNT_W'(1);
      end
      r_fase     <= w_fase_sig;
      r_conf     <= w_conf_sig;
      r_perd     <= w_perd_sig;
      r_valido   <= (w_estado_sig == SINCRONIZADO);
      r_palabra  <= w_palabra_sig;
      r_lista    <= w_lista_sig;
      r_perdidas <= w_perdidas_sig;
    end
  end

  assign bus.valido        = r_valido;
  assign bus.palabra       = r_palabra;
  assign bus.palabra_lista = r_lista;
  assign bus.estado        = r_estado;
  assign bus.perdidas      = r_perdidas;

endmodule
`default_nettype wire

// File: tb/tb_control_sincronia.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_sincronia
// Description : Self-checking bench for control_sincronia with default
//               parameters. A bit-history reference model decides, after
//               every clock edge, what each output must be.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sincronia;

  localparam int         W    = 5;
  localparam logic [4:0] SEQ  = 5'b10100;
  localparam logic [4:0] REIN = 5'b00000;
  localparam int         NC   = 2;
  localparam int         MP   = 2;

  logic clk;
  logic rst;

  control_sincronia_if #(.ANCHO(W)) bus ();

  control_sincronia #(
    .ANCHO        (W),
    .SECUENCIA    (SEQ),
    .SEC_REINICIO (REIN),
    .N_CONFIRMA   (NC),
    .M_PIERDE     (MP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_aserciones = 0;
  int n_fallos     = 0;

  // Reference model: 0 hunt, 1 confirm, 2 locked. Word boundaries are
  // found arithmetically from the bit index of the last hunt match.
  bit   hist[$];
  int   m_n, m_ancla, m_modo, m_conf, m_perd, m_perdidas;
  logic [4:0] m_palabra;
  bit   m_lista;

  task automatic modelo_reset();
    hist.delete();
    m_n = 0; m_ancla = 0; m_modo = 0; m_conf = 0; m_perd = 0;
    m_perdidas = 0; m_palabra = '0; m_lista = 0;
  endtask

  task automatic modelo(input bit b, input bit f);
    int win;
    bit frontera;
    hist.push_back(b);
    m_n++;
    win = 0;
    if (m_n >= W)
      for (int i = m_n - W; i < m_n; i++) win = win * 2 + int'(hist[i]);
    frontera = ((m_n - m_ancla) % W) == 0;
    m_lista = 0;
    if (m_modo != 0 && f) begin
      m_modo = 0; m_conf = 0; m_perd = 0;
    end else if (m_modo == 0) begin
      if (m_n >= W && win == int'(SEQ)) begin
        m_ancla = m_n;
        if (NC == 1) begin m_modo = 2; m_perd = 0; end
        else begin m_modo = 1; m_conf = 1; end
      end
    end else if (m_modo == 1) begin
      if (frontera) begin
        if (win == int'(SEQ)) begin
          m_conf++;
          if (m_conf == NC) begin m_modo = 2; m_perd = 0; m_conf = 0; end
        end else begin
          m_modo = 0; m_conf = 0;
        end
      end
    end else begin
      if (frontera) begin
        m_palabra = win[4:0];
        m_lista   = 1;
        if (win == int'(REIN)) begin
          m_perd++;
          if (m_perd == MP) begin
            m_modo = 0; m_perd = 0;
            if (m_perdidas < 255) m_perdidas++;
          end
        end else begin
          m_perd = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_aserciones++;
    assert (obs === exp)
    else begin
      n_fallos++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_todo(input string pre);
    chk({pre, ".valido"},   32'(bus.valido),        32'(m_modo == 2));
    chk({pre, ".estado"},   32'(bus.estado),        32'(m_modo));
    chk({pre, ".palabra"},  32'(bus.palabra),       32'(m_palabra));
    chk({pre, ".lista"},    32'(bus.palabra_lista), 32'(m_lista));
    chk({pre, ".perdidas"}, 32'(bus.perdidas),      32'(m_perdidas));
  endtask

  task automatic send_bit(input bit b, input bit f);
    bus.s_in = b;
    bus.forzar_busqueda = f;
    @(posedge clk);
    modelo(b, f);
    #1;
    chk_todo("paso");
    bus.forzar_busqueda = 1'b0;
  endtask

  task automatic send_word(input logic [4:0] w, input bit f_ultimo);
    for (int i = 4; i >= 0; i--) send_bit(w[i], (i == 0) && f_ultimo);
  endtask

  // Reset asserted between clock edges; outputs must clear at once.
  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    modelo_reset();
    chk_todo("reset_async");
    repeat (2) @(posedge clk);
    #1;
    chk_todo("reset_hold");
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] hunt_bits;
    logic [4:0]  w;
    int          r;

    rst = 1'b0;
    bus.s_in = 1'b0;
    bus.forzar_busqueda = 1'b0;
    modelo_reset();
    #3;
    chk_todo("reset_inicial");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Sliding hunt: 1,1,0,1,0,1,0,0 then 10100.
    hunt_bits = 13'b1101010010100;
    for (int i = 12; i >= 0; i--) begin
      send_bit(hunt_bits[i], 1'b0);
      if (i == 6)  chk("hunt_no_match_bit7", 32'(bus.estado), 32'd0);
      if (i == 5)  chk("hunt_confirm_bit8",  32'(bus.estado), 32'd1);
      if (i == 0)  chk("hunt_lock_bit13",    32'(bus.valido), 32'd1);
    end

    // Hold and loss.
    send_word(5'b11001, 1'b0);
    chk("hold_word1", 32'(bus.palabra), 32'h19);
    send_word(5'b00000, 1'b0);
    send_word(5'b01110, 1'b0);
    chk("hold_single_rein", 32'(bus.valido), 32'd1);
    send_word(5'b00000, 1'b0);
    send_word(5'b00000, 1'b0);
    chk("loss_estado",   32'(bus.estado),   32'd0);
    chk("loss_perdidas", 32'(bus.perdidas), 32'd1);

    // Re-lock after loss.
    send_word(SEQ, 1'b0);
    send_word(SEQ, 1'b0);
    chk("relock_valido", 32'(bus.valido), 32'd1);

    // Forced re-hunt on a boundary of a reset word.
    send_word(5'b00000, 1'b1);
    chk("force_estado",   32'(bus.estado),        32'd0);
    chk("force_lista",    32'(bus.palabra_lista), 32'd0);
    chk("force_perdidas", 32'(bus.perdidas),      32'd1);

    // Re-lock and second loss.
    send_word(SEQ, 1'b0);
    send_word(SEQ, 1'b0);
    send_word(REIN, 1'b0);
    send_word(REIN, 1'b0);
    chk("second_loss_perdidas", 32'(bus.perdidas), 32'd2);

    // Reset mid-word while locked.
    send_word(SEQ, 1'b0);
    send_word(SEQ, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    do_reset();

    // Failed confirm.
    send_word(SEQ, 1'b0);
    chk("failconf_confirm", 32'(bus.estado), 32'd1);
    send_word(5'b11001, 1'b0);
    chk("failconf_back", 32'(bus.estado), 32'd0);

    // Randomised words, bit slips, forced re-hunts and resets.
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 9);
      if (r < 3)      w = SEQ;
      else if (r < 6) w = REIN;
      else            w = 5'($urandom);
      if ($urandom_range(0, 7) == 0) send_bit(1'($urandom), 1'b0);
      for (int i = 4; i >= 0; i--)
        send_bit(w[i], $urandom_range(0, 39) == 0);
      if ($urandom_range(0, 149) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_aserciones, n_fallos);
    $finish;
  end

endmodule
`default_nettype wire
